muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that owns the HI/LO register pair and sits directly upstream of the ALU's MFHI/MFLO path.
- The ALU reads oHI/oLO to produce the MFHI/MFLO result.
- The hazard unit uses oBusy to stall any instruction that touches HI/LO.
- It replaces single-cycle multiply/divide with a 32-iteration shift-add multiplier and a restoring divider, keeping the EX stage's critical path short.

---
 rtl/muldiv_unit_pkg.sv | 43 ++++
 rtl/muldiv_core.sv | 34 +++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode constants plus the multiply/divide unit's state type and iteration count.
// Helper functions classify an opcode by class so every user decodes it the same way.
package muldiv_unit_pkg;

    localparam logic [4:0] OPMULT  = 5'd10;
    localparam logic [4:0] OPMULTU = 5'd11;
    localparam logic [4:0] OPDIV   = 5'd12;
    localparam logic [4:0] OPDIVU  = 5'd13;
    localparam logic [4:0] OPMADD  = 5'd14;
    localparam logic [4:0] OPMADDU = 5'd15;
    localparam logic [4:0] OPMSUB  = 5'd16;
    localparam logic [4:0] OPMSUBU = 5'd17;
    localparam logic [4:0] OPMTHI  = 5'd18;
    localparam logic [4:0] OPMTLO  = 5'd19;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_RUN,
        MDU_FINISH
    } mdu_state_t;

    function automatic logic is_iter_op(input logic [4:0] op);
        case (op)
            OPMULT, OPMULTU, OPDIV, OPDIVU,
            OPMADD, OPMADDU, OPMSUB, OPMSUBU: is_iter_op = 1'b1;
            default:                          is_iter_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        is_div_op = (op == OPDIV) || (op == OPDIVU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        case (op)
            OPMULT, OPDIV, OPMADD, OPMSUB: is_signed_op = 1'b1;
            default:                       is_signed_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the shift-add multiplier or the restoring divider, purely combinational.
// work holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   work_in,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   work_out
);

    logic [WIDTH:0]   mul_sum;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    always_comb begin
        mul_sum = {1'b0, work_in[2*WIDTH-1:WIDTH]} + (work_in[0] ? {1'b0, opnd} : '0);
        // The shifted remainder needs WIDTH+1 bits for the compare, but after a
        // successful subtract it is below the divisor, so WIDTH bits suffice.
        div_ge  = work_in[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
        div_rem = work_in[2*WIDTH-2:WIDTH-1] - opnd;

        if (is_div) begin
            if (div_ge) begin
                work_out = {div_rem, work_in[WIDTH-2:0], 1'b1};
            end else begin
                work_out = {work_in[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            work_out = {mul_sum, work_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide owning HI/LO; result commits 33 edges after launch with a oDone pulse.
// No backpressure: iStart is dropped while busy, the hazard unit must stall; iAbort cancels.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [4:0]       iControlSignal,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iAbort,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    localparam int CNT_W = $clog2(ITER_COUNT) + 1;

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] work_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] hilo;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign op_signed = is_signed_op(iControlSignal);
    assign a_neg     = op_signed & iA[WIDTH-1];
    assign b_neg     = op_signed & iB[WIDTH-1];
    assign a_mag     = a_neg ? -iA : iA;
    assign b_mag     = b_neg ? -iB : iB;

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .is_div   (is_div_op(op_q)),
        .work_in  (work_q),
        .opnd     (opnd_q),
        .work_out (work_step)
    );

    // Sign fix-up applied once at the end rather than per iteration.
    assign prod = neg_q ? -work_q : work_q;
    assign quo  = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign rem  = rem_neg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    assign hilo = {hi_q, lo_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        divz_d    = divz_q;
        dvd_d     = dvd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (iStart && !iAbort) begin
                    if (is_iter_op(iControlSignal)) begin
                        op_d      = iControlSignal;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        divz_d    = (iB == '0);
                        dvd_d     = iA;
                        cnt_d     = '0;
                        state_d   = MDU_RUN;
                        if (is_div_op(iControlSignal)) begin
                            work_d = {{WIDTH{1'b0}}, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            work_d = {{WIDTH{1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                    end else if (iControlSignal == OPMTHI) begin
                        hi_d = iA;
                    end else if (iControlSignal == OPMTLO) begin
                        lo_d = iA;
                    end
                end
            end

            MDU_RUN: begin
                if (iAbort) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                        state_d = MDU_FINISH;
                    end
                end
            end

            MDU_FINISH: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
                if (!iAbort) begin
                    done_d = 1'b1;
                    if (is_div_op(op_q)) begin
                        if (divz_q) begin
                            lo_d = '1;
                            hi_d = dvd_q;
                        end else begin
                            lo_d = quo;
                            hi_d = rem;
                        end
                    end else if (op_q == OPMADD || op_q == OPMADDU) begin
                        {hi_d, lo_d} = hilo + prod;
                    end else if (op_q == OPMSUB || op_q == OPMSUBU) begin
                        {hi_d, lo_d} = hilo - prod;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end

            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            work_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            divz_q    <= 1'b0;
            dvd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            work_q    <= work_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            divz_q    <= divz_d;
            dvd_q     <= dvd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign oBusy = (state_q != MDU_IDLE);
    assign oDone = done_q;
    assign oHI   = hi_q;
    assign oLO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO from an arithmetic model,
// an independent monitor pops and compares on every oDone.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic [4:0]  iControlSignal;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        iAbort;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oHI;
    logic [31:0] oLO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic        prev_done = 1'b0;
    logic [4:0]  ops [10];

    muldiv_unit #(.WIDTH(32)) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iStart         (iStart),
        .iControlSignal (iControlSignal),
        .iA             (iA),
        .iB             (iB),
        .iAbort         (iAbort),
        .oBusy          (oBusy),
        .oDone          (oDone),
        .oHI            (oHI),
        .oLO            (oLO)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Architectural HI/LO model using plain 64-bit arithmetic.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0]        ua, ub, hl;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        hl = {m_hi, m_lo};
        case (op)
            OPMULT:  hl = sa * sb;
            OPMULTU: hl = ua * ub;
            OPMADD:  hl = hl + (sa * sb);
            OPMADDU: hl = hl + (ua * ub);
            OPMSUB:  hl = hl - (sa * sb);
            OPMSUBU: hl = hl - (ua * ub);
            OPDIV: begin
                if (b == 32'd0) hl = {a, 32'hFFFFFFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    hl = {sr[31:0], sq[31:0]};
                end
            end
            OPDIVU: begin
                if (b == 32'd0) hl = {a, 32'hFFFFFFFF};
                else hl = {32'(ua % ub), 32'(ua / ub)};
            end
            OPMTHI:  hl[63:32] = a;
            OPMTLO:  hl[31:0]  = a;
            default: ;
        endcase
        m_hi = hl[63:32];
        m_lo = hl[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h80000000;
            3:       return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
        exp_t e;
        if (track) model(op, a, b);
        iStart = 1'b1;
        iControlSignal = op;
        iA = a;
        iB = b;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        iA = $urandom;
        iB = $urandom;
        if (track) begin
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge iCLK);
            iA = $urandom;
            iB = $urandom;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b, 1'b1);
        @(negedge iCLK);
        chk("busy_after_launch", {31'd0, oBusy}, 32'd1);
        wait_idle();
    endtask

    task automatic mt(input logic [4:0] op, input logic [31:0] a);
        model(op, a, 32'd0);
        iStart = 1'b1;
        iControlSignal = op;
        iA = a;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        @(negedge iCLK);
        chk("mt_busy", {31'd0, oBusy}, 32'd0);
        chk("mt_hi", oHI, m_hi);
        chk("mt_lo", oLO, m_lo);
    endtask

    task automatic quiet_window(input string name);
        repeat (40) @(negedge iCLK);
        chk(name, {31'd0, oBusy}, 32'd0);
    endtask

    // Monitor: every oDone must match the oldest pending expectation.
    always @(negedge iCLK) begin
        exp_t e;
        if (iRST && oDone) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            chk("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_hi", oHI, e.hi);
                chk("res_lo", oLO, e.lo);
                chk("latency", 32'(cyc - e.cyc), 32'd33);
                chk("busy_at_done", {31'd0, oBusy}, 32'd0);
            end
        end
        prev_done <= oDone;
    end

    initial begin
        ops = '{OPMULT, OPMULTU, OPDIV, OPDIVU, OPMADD, OPMADDU, OPMSUB, OPMSUBU, OPMTHI, OPMTLO};
        iRST = 1'b0;
        iStart = 1'b0;
        iAbort = 1'b0;
        iControlSignal = 5'd0;
        iA = 32'd0;
        iB = 32'd0;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b1;
        @(negedge iCLK);
        chk("rst_hi", oHI, 32'd0);
        chk("rst_lo", oLO, 32'd0);
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_done", {31'd0, oDone}, 32'd0);

        // Reset in the middle of a MULT discards everything.
        mt(OPMTHI, 32'h12345678);
        mt(OPMTLO, 32'h9ABCDEF0);
        launch(OPMULT, 32'd5, 32'd7, 1'b0);
        repeat (10) @(posedge iCLK);
        #1 iRST = 1'b0;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge iCLK);
        chk("midrun_rst_hi", oHI, 32'd0);
        chk("midrun_rst_lo", oLO, 32'd0);
        chk("midrun_rst_busy", {31'd0, oBusy}, 32'd0);
        quiet_window("post_rst_idle");

        run_op(OPMULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi", oHI, 32'hFFFFFFFF);
        chk("mult_lo", oLO, 32'hFFFFFFFA);
        run_op(OPMULTU, 32'hFFFFFFFE, 32'd3);
        chk("multu_hi", oHI, 32'h00000002);
        chk("multu_lo", oLO, 32'hFFFFFFFA);

        run_op(OPDIV, 32'hFFFFFFF9, 32'd2);
        chk("div_hi", oHI, 32'hFFFFFFFF);
        chk("div_lo", oLO, 32'hFFFFFFFD);
        run_op(OPDIVU, 32'd7, 32'd0);
        chk("divz_hi", oHI, 32'h00000007);
        chk("divz_lo", oLO, 32'hFFFFFFFF);
        run_op(OPDIV, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf_hi", oHI, 32'h00000000);
        chk("divovf_lo", oLO, 32'h80000000);

        mt(OPMTHI, 32'h0);
        mt(OPMTLO, 32'hFFFFFFFF);
        run_op(OPMADDU, 32'd1, 32'd1);
        chk("maddu_hi", oHI, 32'h00000001);
        chk("maddu_lo", oLO, 32'h00000000);
        run_op(OPMSUB, 32'd1, 32'd1);
        chk("msub_hi", oHI, 32'h00000000);
        chk("msub_lo", oLO, 32'hFFFFFFFF);

        // A second iStart while busy must not disturb the first result.
        launch(OPMULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        repeat (9) @(posedge iCLK);
        #1;
        iStart = 1'b1;
        iControlSignal = OPMULTU;
        iA = 32'h10;
        iB = 32'h10;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        wait_idle();
        chk("ignored_start_hi", oHI, 32'hFFFFFFFF);
        chk("ignored_start_lo", oLO, 32'hFFFFFFFA);
        quiet_window("ignored_start_idle");

        // Abort at cycle 20 of a DIV, then relaunch immediately.
        launch(OPDIV, 32'd100, 32'd7, 1'b0);
        repeat (19) @(posedge iCLK);
        #1 iAbort = 1'b1;
        @(posedge iCLK);
        #1 iAbort = 1'b0;
        @(negedge iCLK);
        chk("abort_busy", {31'd0, oBusy}, 32'd0);
        chk("abort_hi", oHI, m_hi);
        chk("abort_lo", oLO, m_lo);
        run_op(OPMULT, 32'h1234, 32'h5678);
        chk("after_abort_lo", oLO, 32'h06260060);

        // Abort beats start in IDLE; an unknown opcode launches nothing.
        iStart = 1'b1;
        iAbort = 1'b1;
        iControlSignal = OPMULT;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        iAbort = 1'b0;
        @(negedge iCLK);
        chk("abort_vs_start_busy", {31'd0, oBusy}, 32'd0);
        quiet_window("abort_vs_start_idle");
        iStart = 1'b1;
        iControlSignal = 5'd31;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        @(negedge iCLK);
        chk("bad_op_busy", {31'd0, oBusy}, 32'd0);
        chk("bad_op_hi", oHI, m_hi);
        chk("bad_op_lo", oLO, m_lo);

        for (int i = 0; i < 50; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (ops[k] == OPMTHI || ops[k] == OPMTLO) mt(ops[k], pick());
            else run_op(ops[k], pick(), pick());
        end
        quiet_window("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
